// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard controller.
//   REG_W / FWD_W / RSRC_W / PCSRC_W : field widths
//   forward_e  : Execute ALU operand source select
//   pc_src_e   : next-PC select codes
//   RESULT_SRC_LOAD : result_src code for a load (memory data)
package hazard_unit_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned FWD_W   = 2;
  localparam int unsigned RSRC_W  = 3;
  localparam int unsigned PCSRC_W = 2;

  typedef enum logic [FWD_W-1:0] {
    NO_FORWARD  = 2'b00,
    WB_FORWARD  = 2'b01,
    MEM_FORWARD = 2'b10
  } forward_e;

  localparam logic [RSRC_W-1:0] RESULT_SRC_LOAD = 3'b100;

  typedef enum logic [PCSRC_W-1:0] {
    PC_SRC_PLUS4    = 2'b00,
    PC_SRC_PREDICT  = 2'b01,
    PC_SRC_ROLLBACK = 2'b11
  } pc_src_e;

  // Bit 1 of any pc_src code marks a redirect / mispredict correction.
  localparam int unsigned PC_SRC_REDIRECT_BIT = 1;

  function automatic logic is_redirect(input logic [PCSRC_W-1:0] pc_src);
    return pc_src[PC_SRC_REDIRECT_BIT];
  endfunction

endpackage

// File: rtl/hazard_unit_forward_sel.sv
// Forwarding select for one Execute source operand.
//   rs          : Execute source register
//   rd_m / reg_write_m : Memory stage destination and write enable
//   rd_w / reg_write_w : Writeback stage destination and write enable
//   forward     : operand source (NO/WB/MEM_FORWARD), combinational
module hazard_unit_forward_sel
  import hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd_m,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_w,
  output logic [FWD_W-1:0] forward
);

  // x0 is never forwarded; the younger Memory result wins over Writeback.
  always_comb begin
    forward = NO_FORWARD;
    if (rs != '0) begin
      if (reg_write_m && (rs == rd_m)) begin
        forward = MEM_FORWARD;
      end else if (reg_write_w && (rs == rd_w)) begin
        forward = WB_FORWARD;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Central hazard controller for the five-stage core (F/D/E/M/W).
// Produces Execute forwarding selects, load-use stalls, and the per-stage
// stall/flush controls for I-cache misses and branch redirects.
// All outputs are combinational; clock, reset and the replacement enable are
// accepted for interface uniformity only.
//   inputs : clk_i, reset_i, instr_miss_f_i, rs1/rs2_d_i, rs1/rs2_e_i, rd_e_i,
//            result_src_e_i, pc_src_i, rd_m_i, reg_write_m_i, rd_w_i,
//            reg_write_w_i, pc_src_reg_i, instr_cache_rep_en_i
//   outputs: stall_{f,d,e,m,w}_o, flush_{d,e}_o, forward_{a,b}_e_o
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               instr_miss_f_i,
  input  logic [REG_W-1:0]   rs1_d_i,
  input  logic [REG_W-1:0]   rs2_d_i,
  input  logic [REG_W-1:0]   rs1_e_i,
  input  logic [REG_W-1:0]   rs2_e_i,
  input  logic [REG_W-1:0]   rd_e_i,
  input  logic [RSRC_W-1:0]  result_src_e_i,
  input  logic [PCSRC_W-1:0] pc_src_i,
  input  logic [REG_W-1:0]   rd_m_i,
  input  logic               reg_write_m_i,
  input  logic [REG_W-1:0]   rd_w_i,
  input  logic               reg_write_w_i,
  input  logic [PCSRC_W-1:0] pc_src_reg_i,
  input  logic               instr_cache_rep_en_i,
  output logic               stall_f_o,
  output logic               stall_d_o,
  output logic               stall_e_o,
  output logic               stall_m_o,
  output logic               stall_w_o,
  output logic               flush_d_o,
  output logic               flush_e_o,
  output logic [FWD_W-1:0]   forward_a_e_o,
  output logic [FWD_W-1:0]   forward_b_e_o
);

  logic load_stall;
  logic redirect;
  logic redirect_prev;
  logic miss;

  // Inputs that intentionally influence no output.
  logic unused_inputs;
  assign unused_inputs = ^{clk_i, reset_i, instr_cache_rep_en_i,
                           pc_src_i[0], pc_src_reg_i[0]};

  hazard_unit_forward_sel u_forward_a (
    .rs          (rs1_e_i),
    .rd_m        (rd_m_i),
    .reg_write_m (reg_write_m_i),
    .rd_w        (rd_w_i),
    .reg_write_w (reg_write_w_i),
    .forward     (forward_a_e_o)
  );

  hazard_unit_forward_sel u_forward_b (
    .rs          (rs2_e_i),
    .rd_m        (rd_m_i),
    .reg_write_m (reg_write_m_i),
    .rd_w        (rd_w_i),
    .reg_write_w (reg_write_w_i),
    .forward     (forward_b_e_o)
  );

  // Load in Execute whose destination a Decode source needs next cycle.
  always_comb begin
    load_stall = 1'b0;
    if ((result_src_e_i == RESULT_SRC_LOAD) && (rd_e_i != '0) &&
        ((rs1_d_i == rd_e_i) || (rs2_d_i == rd_e_i))) begin
      load_stall = 1'b1;
    end
  end

  assign redirect      = is_redirect(pc_src_i);
  assign redirect_prev = is_redirect(pc_src_reg_i);
  assign miss          = instr_miss_f_i;

  // Once the redirect is registered, fetch is released during a miss so the
  // corrected PC loads; E is flushed then even though the miss stalls it,
  // since the E register gives flush priority over stall.
  always_comb begin
    stall_f_o = load_stall | (miss & ~redirect_prev);
    stall_d_o = load_stall | miss;
    stall_e_o = miss;
    stall_m_o = miss;
    stall_w_o = miss;
    flush_d_o = redirect;
    flush_e_o = (redirect & (~miss | redirect_prev)) | (load_stall & ~miss);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// stimulus compared against a behavioural reference model.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       miss;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [2:0] result_src_e;
  logic [1:0] pc_src, pc_src_reg;
  logic       reg_write_m, reg_write_w, rep_en;

  logic       stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e;
  logic [1:0] forward_a, forward_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk_i                (clk),
    .reset_i              (reset),
    .instr_miss_f_i       (miss),
    .rs1_d_i              (rs1_d),
    .rs2_d_i              (rs2_d),
    .rs1_e_i              (rs1_e),
    .rs2_e_i              (rs2_e),
    .rd_e_i               (rd_e),
    .result_src_e_i       (result_src_e),
    .pc_src_i             (pc_src),
    .rd_m_i               (rd_m),
    .reg_write_m_i        (reg_write_m),
    .rd_w_i               (rd_w),
    .reg_write_w_i        (reg_write_w),
    .pc_src_reg_i         (pc_src_reg),
    .instr_cache_rep_en_i (rep_en),
    .stall_f_o            (stall_f),
    .stall_d_o            (stall_d),
    .stall_e_o            (stall_e),
    .stall_m_o            (stall_m),
    .stall_w_o            (stall_w),
    .flush_d_o            (flush_d),
    .flush_e_o            (flush_e),
    .forward_a_e_o        (forward_a),
    .forward_b_e_o        (forward_b)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
  endtask

  // Reference: forwarding source for one operand.
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    int src;
    src = 0;                                   // register file
    if (rs != 0) begin
      if (reg_write_w && rs == rd_w) src = 1;  // older result
      if (reg_write_m && rs == rd_m) src = 2;  // younger result overrides
    end
    return 2'(src);
  endfunction

  // Reference: {stall_f,d,e,m,w, flush_d, flush_e} from the current inputs.
  function automatic logic [6:0] ref_ctrl();
    bit ld, rdr, rdr_prev, sf, sd, fd, fe;
    ld       = (result_src_e == 3'd4) && (rd_e != 0) &&
               (rs1_d == rd_e || rs2_d == rd_e);
    rdr      = pc_src >= 2'd2;
    rdr_prev = pc_src_reg >= 2'd2;
    sf = ld || (miss && !rdr_prev);
    sd = ld || miss;
    fd = rdr;
    fe = (rdr && (!miss || rdr_prev)) || (ld && !miss);
    return {sf, sd, miss, miss, miss, fd, fe};
  endfunction

  function automatic logic [6:0] obs_ctrl();
    return {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e};
  endfunction

  task automatic clear_inputs();
    miss = 0; rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0;
    rd_m = 0; rd_w = 0; result_src_e = 0; pc_src = 0; pc_src_reg = 0;
    reg_write_m = 0; reg_write_w = 0; rep_en = 0;
  endtask

  // Check all outputs against the model, sampled on the falling edge.
  task automatic model_check(input string tag);
    @(negedge clk);
    check({tag, "_ctrl"}, 32'(obs_ctrl()), 32'(ref_ctrl()));
    check({tag, "_fwd_a"}, 32'(forward_a), 32'(ref_fwd(rs1_e)));
    check({tag, "_fwd_b"}, 32'(forward_b), 32'(ref_fwd(rs2_e)));
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;

    // Outputs track inputs during reset.
    @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 32'(obs_ctrl()), 32'h0);
    check("reset_fwd", 32'({forward_a, forward_b}), 32'h0);
    @(posedge clk);
    miss = 1;
    @(negedge clk);
    check("reset_miss", 32'(obs_ctrl()), 32'b1111100);
    @(posedge clk);
    reset = 1'b0;
    clear_inputs();

    // Forwarding sweep over rd_m, then rd_w (rd_m fixed at 5 to show M priority).
    for (int rs = 0; rs < 32; rs++) begin
      for (int rd = 0; rd < 32; rd++) begin
        @(posedge clk);
        rs1_e = 5'(rs); rs2_e = 5'(31 - rs);
        rd_m = 5'(rd); reg_write_m = 1; reg_write_w = 0; rd_w = 0;
        model_check("sweep_m");
      end
    end
    for (int rs = 0; rs < 32; rs++) begin
      for (int rd = 0; rd < 32; rd++) begin
        @(posedge clk);
        rs1_e = 5'(rs); rs2_e = 5'(31 - rs);
        rd_m = 5'd5; reg_write_m = 1; rd_w = 5'(rd); reg_write_w = 1;
        model_check("sweep_w");
      end
    end
    // Explicit forwarding points.
    @(posedge clk);
    rs1_e = 5; rs2_e = 7; rd_m = 5; rd_w = 7; reg_write_m = 1; reg_write_w = 1;
    @(negedge clk);
    check("fwd_mem", 32'(forward_a), 32'h2);
    check("fwd_wb", 32'(forward_b), 32'h1);
    @(posedge clk);
    rs1_e = 7; rd_m = 7;
    @(negedge clk);
    check("fwd_m_wins", 32'(forward_a), 32'h2);
    @(posedge clk);
    rs1_e = 0; rd_m = 0; rd_w = 0;
    @(negedge clk);
    check("fwd_x0", 32'(forward_a), 32'h0);
    clear_inputs();

    // Load-use on rs1, then rs2; then no hazard.
    @(posedge clk);
    result_src_e = 3'b100; rd_e = 1; rs1_d = 1;
    @(negedge clk);
    check("load_rs1", 32'(obs_ctrl()), 32'b1100001);
    @(posedge clk);
    rd_e = 2; rs1_d = 0; rs2_d = 2;
    @(negedge clk);
    check("load_rs2", 32'(obs_ctrl()), 32'b1100001);
    @(posedge clk);
    result_src_e = 0; rd_e = 1; rs1_d = 0; rs2_d = 0;
    @(negedge clk);
    check("no_hazard", 32'(obs_ctrl()), 32'b0000000);
    @(posedge clk);
    result_src_e = 3'b100; rd_e = 0; rs1_d = 0;
    @(negedge clk);
    check("load_x0", 32'(obs_ctrl()), 32'b0000000);
    clear_inputs();

    // Cache miss with predicted PC+4.
    @(posedge clk);
    miss = 1; rep_en = 1; pc_src = 2'b00;
    @(negedge clk);
    check("miss_plus4", 32'(obs_ctrl()), 32'b1111100);
    // Hit with mispredict.
    @(posedge clk);
    miss = 0; rep_en = 0; pc_src = 2'b11;
    @(negedge clk);
    check("hit_mispredict", 32'(obs_ctrl()), 32'b0000011);

    // Miss + mispredict sequence, cycle-3 miss = 1 then 0.
    for (int m3 = 1; m3 >= 0; m3--) begin
      @(posedge clk);
      miss = 1; pc_src = 2'b11; pc_src_reg = 2'b00;
      @(negedge clk);
      check("seq_c1", 32'(obs_ctrl()), 32'b1111110);
      @(posedge clk);
      pc_src_reg = 2'b11;
      @(negedge clk);
      check("seq_c2", 32'(obs_ctrl()), 32'b0111111);
      @(posedge clk);
      miss = 1'(m3); pc_src = 2'b00; pc_src_reg = 2'b00;
      @(negedge clk);
      check("seq_c3", 32'(obs_ctrl()), m3 != 0 ? 32'b1111100 : 32'b0000000);
    end

    // Miss with correct prediction, rep_en 0 then 1.
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      miss = 1; pc_src = 2'b01; pc_src_reg = 2'b01; rep_en = 1'(r);
      @(negedge clk);
      check("miss_predict", 32'(obs_ctrl()), 32'b1111100);
    end
    clear_inputs();

    // Randomized stimulus, register numbers biased toward collisions.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      reset        = ($urandom_range(0, 15) == 0);
      miss         = 1'($urandom_range(0, 1));
      rs1_d        = 5'($urandom_range(0, 3));
      rs2_d        = 5'($urandom_range(0, 3));
      rs1_e        = 5'($urandom_range(0, 3));
      rs2_e        = 5'($urandom_range(0, 3));
      rd_e         = 5'($urandom_range(0, 3));
      rd_m         = 5'($urandom_range(0, 3));
      rd_w         = 5'($urandom_range(0, 3));
      result_src_e = ($urandom_range(0, 1) != 0) ? 3'b100 : 3'($urandom);
      pc_src       = 2'($urandom);
      pc_src_reg   = 2'($urandom);
      reg_write_m  = 1'($urandom);
      reg_write_w  = 1'($urandom);
      rep_en       = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        rs1_e = 5'($urandom); rd_m = 5'($urandom); rd_w = 5'($urandom);
      end
      model_check("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
